// File: rtl/mem_access_unit_if.sv
// ============================================================================
// Module      : mem_access_unit_if
// Description : Bundles the request/response handshake and the memory bus
//               of mem_access_unit. The 'slave' modport is the unit's view.
//               The 'master' modport is the view of the surrounding
//               environment, which drives requests and models memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_access_unit_if;
   // request side
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   // response side
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   // memory bus
   logic        mem_req;
   logic        mem_we;
   logic [3:0]  mem_be;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err,
      output mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err,
      input  mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );
endinterface

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module      : mem_access_unit
// Description : Single-outstanding RV32I load/store unit. It accepts one
//               request and issues a word-aligned memory access with byte
//               enables and lane-replicated store data. Load data is
//               extracted and sign/zero extended. A bounded wait for
//               mem_rvalid is applied, and unsupported accesses are
//               reported via resp_err.
//               Optional build macro: MISALIGN_TRAP_EN. When it is defined,
//               misaligned half/word accesses are rejected with resp_err.
//               When it is undefined, the low address bits are forced to
//               zero and the access proceeds normally.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit #(
   parameter int TIMEOUT = 16   // max WAIT cycles for mem_rvalid (1..255)
) (
   input  logic               clk,
   input  logic               rst_n,
   mem_access_unit_if.slave   bus
);

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic [2:0]  funct3_q;
   logic [1:0]  lo_q;
   logic        req_ready_q;
   logic        resp_valid_q;
   logic        resp_err_q;
   logic [31:0] resp_rdata_q;
   logic        mem_req_q;
   logic        mem_we_q;
   logic [3:0]  mem_be_q;
   logic [31:0] mem_addr_q;
   logic [31:0] mem_wdata_q;

   // values decoded from the incoming request, captured on acceptance
   logic        supported_d;
   logic        skip_d;
   logic [1:0]  lo_d;
   logic [3:0]  be_d;
   logic [31:0] wdata_d;
   // load data extracted from the memory return word
   logic [7:0]  byte_d;
   logic [15:0] half_d;
   logic [31:0] load_data_d;

   // Decode the request: legality, aligned lane offset, byte enables, store data
   always_comb begin
      supported_d = 1'b0;
      lo_d        = bus.req_addr[1:0];
      be_d        = 4'b1111;
      wdata_d     = 32'd0;

      case (bus.req_funct3)
         3'd0, 3'd1, 3'd2: supported_d = 1'b1;
         3'd4, 3'd5:       supported_d = ~bus.req_we;   // LBU/LHU have no store form
         default:          supported_d = 1'b0;
      endcase

      // halfwords align to addr[1], words to the full word
      case (bus.req_funct3[1:0])
         2'b01:   lo_d = {bus.req_addr[1], 1'b0};
         2'b10:   lo_d = 2'b00;
         default: lo_d = bus.req_addr[1:0];
      endcase

      if (bus.req_we) begin
         case (bus.req_funct3[1:0])
            2'b00: begin
               be_d    = 4'b0001 << lo_d;
               wdata_d = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
               be_d    = 4'b0011 << lo_d;
               wdata_d = {2{bus.req_wdata[15:0]}};
            end
            default: begin
               be_d    = 4'b1111;
               wdata_d = bus.req_wdata;
            end
         endcase
      end

`ifdef MISALIGN_TRAP_EN
      // forced-down offset differing from the raw one means the access is misaligned
      skip_d = ~supported_d | (lo_d != bus.req_addr[1:0]);
`else
      skip_d = ~supported_d;
`endif
   end

   // Select and extend the addressed byte/half of the returned word
   always_comb begin
      case (lo_q)
         2'd0:    byte_d = bus.mem_rdata[7:0];
         2'd1:    byte_d = bus.mem_rdata[15:8];
         2'd2:    byte_d = bus.mem_rdata[23:16];
         default: byte_d = bus.mem_rdata[31:24];
      endcase
      half_d = lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

      if (mem_we_q) begin
         load_data_d = 32'd0;                        // stores return no data
      end else begin
         case (funct3_q)
            3'd0:    load_data_d = {{24{byte_d[7]}}, byte_d};
            3'd1:    load_data_d = {{16{half_d[15]}}, half_d};
            3'd4:    load_data_d = {24'd0, byte_d};
            3'd5:    load_data_d = {16'd0, half_d};
            default: load_data_d = bus.mem_rdata;
         endcase
      end
   end

   // Transaction FSM with all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cnt_q        <= 8'd0;
         funct3_q     <= 3'd0;
         lo_q         <= 2'd0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'd0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_be_q     <= 4'd0;
         mem_addr_q   <= 32'd0;
         mem_wdata_q  <= 32'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.req_valid) begin
                  req_ready_q  <= 1'b0;
                  funct3_q     <= bus.req_funct3;
                  lo_q         <= lo_d;
                  mem_we_q     <= bus.req_we;
                  mem_be_q     <= be_d;
                  mem_addr_q   <= {bus.req_addr[31:2], 2'b00};
                  mem_wdata_q  <= wdata_d;
                  resp_rdata_q <= 32'd0;
                  if (skip_d) begin
                     // rejected accesses never touch memory
                     resp_err_q   <= 1'b1;
                     resp_valid_q <= 1'b1;
                     state_q      <= S_RESP;
                  end else begin
                     resp_err_q <= 1'b0;
                     mem_req_q  <= 1'b1;
                     state_q    <= S_REQ;
                  end
               end
            end

            S_REQ: begin
               // rvalid seen here is stale and deliberately ignored
               if (bus.mem_gnt) begin
                  mem_req_q <= 1'b0;
                  cnt_q     <= 8'd0;
                  state_q   <= S_WAIT;
               end
            end

            S_WAIT: begin
               if (bus.mem_rvalid) begin
                  // rvalid on the final wait cycle still counts as success
                  resp_rdata_q <= load_data_d;
                  resp_err_q   <= 1'b0;
                  resp_valid_q <= 1'b1;
                  state_q      <= S_RESP;
               end else if (cnt_q == TIMEOUT_C - 8'd1) begin
                  cnt_q        <= TIMEOUT_C;          // saturate, never wrap
                  resp_rdata_q <= 32'd0;
                  resp_err_q   <= 1'b1;
                  resp_valid_q <= 1'b1;
                  state_q      <= S_RESP;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end

            S_RESP: begin
               resp_valid_q <= 1'b0;
               req_ready_q  <= 1'b1;
               state_q      <= S_IDLE;
            end

            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_be     = mem_be_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Self-checking bench for mem_access_unit. It runs directed
//               vectors followed by randomized transactions. Each one is
//               checked against an arithmetic reference model of the
//               load/store rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

   localparam int TO = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_err    = 0;

   always #5 clk = ~clk;

   mem_access_unit_if bus ();

   mem_access_unit #(.TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic        skip;
      logic        err;
      logic [31:0] rdata;
      logic [3:0]  be;
      logic [31:0] maddr;
      logic [31:0] mwdata;
   } exp_t;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: access width, lane offset and extension from plain arithmetic
   function automatic exp_t model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] rd, input bit got);
      exp_t        e;
      int          size;
      int          off;
      bit          ok;
      bit          sgn;
      bit          misal;
      logic [31:0] mask;
      logic [31:0] val;
      e     = '0;
      ok    = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      size  = 1 << (int'(f3) % 4);
      sgn   = (f3 < 3'd4);
      off   = int'(a % 4);
      misal = (off % size) != 0;
`ifdef MISALIGN_TRAP_EN
      e.skip = !ok || misal;
`else
      e.skip = !ok;
`endif
      off     = off - (off % size);
      e.maddr = a - (a % 4);
      mask    = (size >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
      if (we) begin
         e.be     = 4'(((1 << size) - 1) << off);
         e.mwdata = (size == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                    (size == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
         val      = 32'd0;
      end else begin
         e.be = 4'hF;
         val  = (rd >> (8 * off)) & mask;
         if (sgn && size < 4 && ((val >> (8 * size - 1)) & 32'd1) == 32'd1) val = val | ~mask;
      end
      e.err   = e.skip || !got;
      e.rdata = (e.skip || !got) ? 32'd0 : val;
      return e;
   endfunction

   // One complete request: gdly = REQ cycles before grant, rdly = WAIT cycle
   // carrying rvalid (-1 for never), stray = rvalid noise while in REQ
   task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] rd,
                      input int gdly, input int rdly, input bit stray);
      exp_t e;
      bit   got;
      int   lat;
      int   wc;
      got = (rdly >= 0) && (rdly < TO);
      e   = model(we, f3, a, wd, rd, got);
      check("ready_idle", 32'(bus.req_ready), 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_wdata  = wd;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_addr  = $urandom;
      bus.req_wdata = $urandom;
      lat = 1;
      if (e.skip) begin
         check("skip_no_memreq", 32'(bus.mem_req), 32'd0);
         check("skip_resp_valid", 32'(bus.resp_valid), 32'd1);
         check("skip_err", 32'(bus.resp_err), 32'd1);
         check("skip_rdata", bus.resp_rdata, 32'd0);
      end else begin
         for (int g = 0; g <= gdly; g++) begin
            check("mem_req_held", 32'(bus.mem_req), 32'd1);
            check("req_ready_busy", 32'(bus.req_ready), 32'd0);
            check("mem_addr", bus.mem_addr, e.maddr);
            check("mem_be", 32'(bus.mem_be), 32'(e.be));
            check("mem_we", 32'(bus.mem_we), 32'(we));
            if (we) check("mem_wdata", bus.mem_wdata, e.mwdata);
            bus.mem_gnt    = (g == gdly);
            bus.mem_rvalid = stray;
            bus.mem_rdata  = $urandom;
            @(negedge clk);
            lat++;
         end
         bus.mem_gnt    = 1'b0;
         bus.mem_rvalid = 1'b0;
         check("mem_req_dropped", 32'(bus.mem_req), 32'd0);
         wc = 0;
         while (!bus.resp_valid && wc < TO + 4) begin
            bus.mem_rvalid = (wc == rdly);
            bus.mem_rdata  = (wc == rdly) ? rd : $urandom;
            @(negedge clk);
            wc++;
            lat++;
         end
         bus.mem_rvalid = 1'b0;
         check("wait_cycles", 32'(wc), got ? 32'(rdly + 1) : 32'(TO));
         if (gdly == 0 && rdly == 0) check("min_latency", 32'(lat), 32'd3);
         check("resp_valid", 32'(bus.resp_valid), 32'd1);
         check("resp_err", 32'(bus.resp_err), 32'(e.err));
         check("resp_rdata", bus.resp_rdata, e.rdata);
      end
      @(negedge clk);
      check("resp_one_cycle", 32'(bus.resp_valid), 32'd0);
      check("ready_back", 32'(bus.req_ready), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
      check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
      check({tag, "_resp_err"}, 32'(bus.resp_err), 32'd0);
      check({tag, "_resp_rdata"}, bus.resp_rdata, 32'd0);
      check({tag, "_mem_req"}, 32'(bus.mem_req), 32'd0);
      check({tag, "_mem_we"}, 32'(bus.mem_we), 32'd0);
      check({tag, "_mem_be"}, 32'(bus.mem_be), 32'd0);
      check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
      check({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'd0;
      bus.req_addr   = 32'd0;
      bus.req_wdata  = 32'd0;
      bus.mem_gnt    = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 32'd0;

      // reset state
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // directed vectors
      txn(1'b0, 3'd0, 32'h0000_0003, 32'd0, 32'h80FF_1234, 0, 0, 1'b0);        // LB
      txn(1'b0, 3'd5, 32'h0000_0002, 32'd0, 32'h8001_ABCD, 0, 0, 1'b0);        // LHU
      txn(1'b0, 3'd1, 32'h0000_0002, 32'd0, 32'h8001_ABCD, 0, 0, 1'b0);        // LH
      txn(1'b1, 3'd0, 32'h0000_0005, 32'h0000_00A5, 32'd0, 0, 0, 1'b0);       // SB
      txn(1'b0, 3'd2, 32'h0000_0010, 32'd0, 32'd0, 3, -1, 1'b0);               // LW timeout
      txn(1'b1, 3'd2, 32'h0000_0006, 32'h1234_5678, 32'd0, 0, 0, 1'b0);       // SW misaligned
      txn(1'b0, 3'd2, 32'h0000_0020, 32'd0, 32'hCAFE_F00D, 1, TO - 1, 1'b1);   // rvalid at expiry
      txn(1'b0, 3'd3, 32'h0000_0000, 32'd0, 32'd0, 0, 0, 1'b0);                // unsupported load
      txn(1'b1, 3'd5, 32'h0000_0000, 32'd0, 32'd0, 0, 0, 1'b0);                // unsupported store
      txn(1'b1, 3'd1, 32'h0000_0007, 32'h0000_BEEF, 32'd0, 2, 1, 1'b1);       // SH misaligned

      // randomized transactions
      for (int i = 0; i < 60; i++) begin
         int rdly;
         case ($urandom_range(0, 9))
            0:       rdly = -1;
            1:       rdly = TO - 1;
            default: rdly = int'($urandom_range(0, 5));
         endcase
         txn(1'(($urandom) % 2), 3'(($urandom) % 8), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)), rdly, 1'(($urandom) % 2));
      end

      // reset while waiting for rvalid, then a stray rvalid afterwards
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'd2;
      bus.req_addr   = 32'h0000_0040;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.mem_gnt   = 1'b1;
      @(negedge clk);
      bus.mem_gnt = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hDEAD_BEEF;
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check_reset_outputs("post_rst");
         @(negedge clk);
      end

      // normal operation resumes after the abort
      txn(1'b0, 3'd4, 32'h0000_0101, 32'd0, 32'h0000_9A00, 0, 0, 1'b0);       // LBU

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum cycles to wait for mem_rvalid after grant (range 1..255).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports req_valid in 1, req_ready out 1, req_we in 1 (1=store), req_funct3 in 3 (RV32I load/store funct3), req_addr in 32, req_wdata in 32.
REQ-005 SHALL have ports resp_valid out 1, resp_rdata out 32 (extended load data), resp_err out 1.
REQ-006 SHALL have ports mem_req out 1, mem_we out 1, mem_be out 4, mem_addr out 32 (word-aligned, bits[1:0]=0), mem_wdata out 32, mem_gnt in 1, mem_rvalid in 1, mem_rdata in 32.

Function
REQ-007 SHALL implement states IDLE, REQ, WAIT, RESP.
REQ-008 IDLE: req_ready=1; on req_valid, SHALL capture we/funct3/addr/wdata and go to REQ the next cycle.
REQ-009 REQ: mem_req=1 held with stable mem_we/be/addr/wdata until mem_gnt=1; on grant, SHALL go to WAIT and clear the timeout counter.
REQ-010 WAIT: counter increments each cycle; on mem_rvalid, SHALL latch result and go to RESP; if counter reaches TIMEOUT without rvalid, SHALL go to RESP with resp_err=1 and resp_rdata=0.
REQ-011 RESP: resp_valid=1 for exactly one cycle, then IDLE; req_ready=0 in REQ, WAIT, RESP.
REQ-012 Minimum latency: req_valid accepted at cycle N, grant and rvalid both immediate -> resp_valid at cycle N+3.
REQ-013 Store byte enables: SB -> 4'b0001<<addr[1:0]; SH -> 4'b0011<<(addr[1]*2); SW -> 4'b1111; wdata replicated per lane (byte x4, half x2).
REQ-014 Load extraction from mem_rdata: LB/LBU select byte addr[1:0], LH/LHU select half addr[1]; LB/LH sign-extend, LBU/LHU zero-extend; LW passes through; loads drive mem_be=4'b1111.
REQ-015 Stores SHALL also wait for mem_rvalid (write ack); resp_rdata=0 for stores.
REQ-016 Unsupported funct3 (load 3,6,7; store 3..7) SHALL skip memory, go directly to RESP with resp_err=1.
REQ-017 mem_rvalid arriving in IDLE or REQ SHALL be ignored; mem_rvalid coinciding with timeout expiry SHALL be treated as success.
REQ-018 Counter SHALL be 8 bits and SHALL not wrap (saturates at TIMEOUT).

Reset
REQ-019 On rst_n=0, state=IDLE immediately, counter=0, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
REQ-020 Reset mid-transaction (REQ/WAIT) SHALL abort with no response; a later stray mem_rvalid SHALL be ignored.

Configuration
REQ-021 Macro MISALIGN_TRAP_EN: when defined, halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL skip memory and respond with resp_err=1 in RESP.
REQ-022 Without MISALIGN_TRAP_EN, misaligned low address bits SHALL be forced to zero (half: addr[0]; word: addr[1:0]) and the access performed normally.

Verification
REQ-023 LB addr=0x00000003, mem_rdata=0x80FF1234, immediate grant/rvalid -> mem_addr=0x0, resp_rdata=0xFFFFFF80, resp_valid 3 cycles after accept.
REQ-024 LHU addr=0x00000002, mem_rdata=0x8001ABCD -> resp_rdata=0x00008001; LH same -> 0xFFFF8001.
REQ-025 SB addr=0x00000005, wdata=0x000000A5 -> mem_addr=0x4, mem_be=4'b0010, mem_wdata=0xA5A5A5A5, mem_we=1.
REQ-026 LW with grant delayed 3 cycles and no rvalid -> mem_req held 4 cycles, resp_err=1, resp_rdata=0 after TIMEOUT=16 wait cycles.
REQ-027 SW addr=0x00000006: with MISALIGN_TRAP_EN -> no mem_req, resp_err=1; without -> mem_addr=0x4, mem_be=4'b1111.
REQ-028 rst_n low during WAIT, then rvalid pulse after release -> no resp_valid, req_ready=1, outputs at reset values.
